data_mem_responder: RTL

- Memory-side end of the processor's load/store interface: accepts ld/st requests from the pipeline's memory stage over valid/ready, services them in order with configurable latency, and returns load data or a store acknowledge.
- Replaces the zero-latency combinational data array, so the pipeline must stall on handshake.
- One clock domain.

---
 rtl/data_mem_responder_pkg.sv | 35 +++
 rtl/data_mem_responder_req_fifo.sv | 81 ++++++++
 rtl/data_mem_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared definitions for the data memory responder: word and
//               address width defaults, the FSM state encoding, the layout
//               of a queued request record {we, addr, wdata}, and the width
//               of the latency down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    // Default word and address widths of the data memory.
    localparam int WORD_W         = 16;
    localparam int ADDR_W_DEFAULT = 16;

    // A queued request is packed as {we, addr, wdata}, we in the MSB.
    localparam int REQ_W = 1 + ADDR_W_DEFAULT + WORD_W;

    // The latency counter must hold LATENCY-1. LATENCY is at most 15.
    localparam int CNT_W = 4;

    // Responder FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Request record width for non-default address/data widths.
    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_req_fifo
// Description : Synchronous request FIFO for the data memory responder.
//               The head entry is presented combinationally on dout. A push
//               while full and a pop while empty are both ignored.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous active-high reset (clears pointers/count)
//               push  - write din at the tail
//               pop   - drop the head entry
//               din   - entry to write
//               dout  - current head entry
//               count - number of stored entries
//               full  - count == DEPTH
//               empty - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder_req_fifo
    import data_mem_responder_pkg::*;
#(
    parameter int WIDTH = REQ_W,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W_F = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic [CNT_W_F-1:0] count,
    output logic               full,
    output logic               empty
);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W_F-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CNT_W_F'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Memory-side end of the load/store interface. Requests are
//               queued in a small FIFO and serviced strictly in order. Each
//               request waits LATENCY cycles before the memory access and is
//               then answered on the response channel. It returns load data,
//               or a store acknowledge with rdata 0.
// Ports       : clk       - clock, rising edge
//               reset     - asynchronous active-high reset
//               req_valid - request present
//               req_ready - request queue can accept (registered count only)
//               req_we    - 1 = store, 0 = load
//               req_addr  - word address
//               req_wdata - store data
//               rsp_valid - response present
//               rsp_ready - response accepted by the pipeline
//               rsp_we    - req_we of the request being answered
//               rsp_rdata - load data, 0 for store acknowledges
//               busy      - queue non-empty or FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int DATA_W     = WORD_W,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam int C_REQ_W      = req_width(ADDR_W, DATA_W);
    localparam int C_FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_LAT_LOAD = CNT_W'(LATENCY - 1);

    // FSM and latency counter
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Working copy of the request in service
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    // Response registers
    logic              r_rsp_we;
    logic [DATA_W-1:0] r_rsp_rdata;

    // Data array, deliberately not cleared by reset
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Control strobes
    logic              w_push;
    logic              w_pop;
    logic              w_access;

    // FIFO interface
    logic [C_REQ_W-1:0]      w_fifo_din;
    logic [C_REQ_W-1:0]      w_fifo_dout;
    logic [C_FIFO_CNT_W-1:0] w_fifo_count;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;

    // Ready comes from the registered count only. A full queue refuses a
    // push even when the FSM pops in the same cycle, so rsp_ready never
    // reaches req_ready combinationally.
    assign req_ready  = !w_fifo_full;
    assign w_push     = req_valid && req_ready;
    assign w_fifo_din = {req_we, req_addr, req_wdata};

    data_mem_responder_req_fifo #(
        .WIDTH (C_REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // The counter is loaded with LATENCY-1 on a pop. The access happens in
    // the WAIT cycle where the counter reads 0, so WAIT lasts LATENCY cycles.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = C_LAT_LOAD;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!w_fifo_empty) begin
                        // Back-to-back: skip IDLE and start the next request.
                        w_pop       = 1'b1;
                        w_cnt_nxt   = C_LAT_LOAD;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Working registers and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_pop) begin
                {r_we, r_addr, r_wdata} <= w_fifo_dout;
            end
            if (w_access) begin
                r_rsp_we    <= r_we;
                r_rsp_rdata <= r_we ? '0 : r_mem[r_addr];
            end
        end
    end

    // The access strobe derives from the async-reset state, so a store that
    // is still in WAIT when reset hits is never written.
    always_ff @(posedge clk) begin
        if (w_access && r_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_we    = r_rsp_we;
    assign rsp_rdata = r_rsp_rdata;
    assign busy      = (w_fifo_count != '0) || (r_state != ST_IDLE);

endmodule
`default_nettype wire
